control_sequencer: RTL and testbench

//  - Multi-cycle instruction/interrupt sequencer directly upstream of the control-select register stage.
//  - Takes decoder output and produces registered instruction_id, clock_counter and interrupt_stage.
//  - Stretches multi-cycle AVR instructions, inserts the 3-stage interrupt entry at instruction boundaries,
//    and gates fetch/PC advance.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/seq_cycle_lut.sv | 26 ++
 rtl/control_sequencer.sv | 101 ++++++++++
 tb/tb_control_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared instruction ids, interrupt-stage encodings and helpers for the control sequencer.
package ctrl_pkg;

    localparam logic [7:0] INT_ID   = 8'hFF;
    localparam logic [7:0] BR_ID_LO = 8'h04;
    localparam logic [7:0] BR_ID_HI = 8'h08;

    localparam logic [7:0] ID_RCALL = 8'h2C;
    localparam logic [7:0] ID_RET   = 8'h2D;
    localparam logic [7:0] ID_RETI  = 8'h2E;
    localparam logic [7:0] ID_LPM   = 8'h22;
    localparam logic [7:0] ID_PUSH  = 8'h2B;
    localparam logic [7:0] ID_POP   = 8'h2A;
    localparam logic [7:0] ID_LD    = 8'h19;
    localparam logic [7:0] ID_ST    = 8'h38;
    localparam logic [7:0] ID_RJMP  = 8'h2F;
    localparam logic [7:0] ID_CLI   = 8'h0A;
    localparam logic [7:0] ID_SEI   = 8'h0B;

    // Stage order during entry is PCL -> PCH -> VEC, hence the non-monotonic encoding.
    typedef enum logic [1:0] {
        IS_IDLE = 2'd0,
        IS_PCH  = 2'd1,
        IS_PCL  = 2'd2,
        IS_VEC  = 2'd3
    } int_stage_e;

    function automatic logic is_branch(input logic [7:0] id);
        return (id >= BR_ID_LO) && (id <= BR_ID_HI);
    endfunction

endpackage

// File: rtl/seq_cycle_lut.sv
// Combinational cycle-count table: maps an instruction id to (cycles - 1), saturated to 2 bits.
module seq_cycle_lut
    import ctrl_pkg::*;
(
    input  logic [7:0] dec_id,
    input  logic       branch_taken,
    output logic [1:0] cycles_m1
);

    always_comb begin
        cycles_m1 = 2'd0;
        if (is_branch(dec_id)) begin
            cycles_m1 = branch_taken ? 2'd1 : 2'd0;
        end else begin
            // RET/RETI take 4 cycles, which is exactly the 2-bit ceiling.
            case (dec_id)
                ID_RCALL, ID_LPM:                       cycles_m1 = 2'd2;
                ID_RET, ID_RETI:                        cycles_m1 = 2'd3;
                ID_PUSH, ID_POP, ID_LD, ID_ST, ID_RJMP: cycles_m1 = 2'd1;
                ID_CLI, ID_SEI:                         cycles_m1 = 2'd0;
                default:                                cycles_m1 = 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction / interrupt-entry sequencer feeding the control-select stage.
// Optional SEQ_STALL_EN adds a 'stall' input that freezes all sequencer state.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dec_id,
    input  logic       dec_valid,
    input  logic       branch_taken,
    input  logic       irq_req,
    input  logic       sreg_i,
`ifdef SEQ_STALL_EN
    input  logic       stall,
`endif
    output logic [7:0] instruction_id,
    output logic [1:0] clock_counter,
    output logic [1:0] interrupt_stage,
    output logic       fetch_en,
    output logic       irq_ack,
    output logic       busy
);

    logic [7:0] id_q, id_d;
    logic [1:0] cnt_q, cnt_d;
    int_stage_e stage_q, stage_d;
    logic       started_q, started_d;
    logic [1:0] lut_cycles_m1;
    logic       stall_i;
    logic       boundary;
    logic       irq_pending;

`ifdef SEQ_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    seq_cycle_lut u_lut (
        .dec_id       (dec_id),
        .branch_taken (branch_taken),
        .cycles_m1    (lut_cycles_m1)
    );

    assign boundary    = (cnt_q == 2'd0) && (stage_q == IS_IDLE);
    assign irq_pending = irq_req && sreg_i;

    always_comb begin
        id_d      = id_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        started_d = 1'b1;
        if (!stall_i) begin
            // Interrupt entry runs to completion regardless of irq_req/sreg_i.
            if (stage_q != IS_IDLE) begin
                case (stage_q)
                    IS_PCL:  stage_d = IS_PCH;
                    IS_PCH:  stage_d = IS_VEC;
                    default: begin
                        stage_d = IS_IDLE;
                        id_d    = 8'h00;
                    end
                endcase
            end else if (cnt_q != 2'd0) begin
                cnt_d = cnt_q - 2'd1;
            end else if (irq_pending) begin
                id_d    = INT_ID;
                stage_d = IS_PCL;
            end else if (dec_valid) begin
                id_d  = dec_id;
                cnt_d = lut_cycles_m1;
            end else begin
                id_d  = 8'h00;
                cnt_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_q      <= 8'h00;
            cnt_q     <= 2'd0;
            stage_q   <= IS_IDLE;
            started_q <= 1'b0;
        end else begin
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            started_q <= started_d;
        end
    end

    // started_q keeps fetch_en low in the first cycle after reset so every output reads 0 there.
    assign fetch_en        = started_q && boundary && !irq_pending && !stall_i;
    assign irq_ack         = (stage_q == IS_VEC) && !stall_i;
    assign busy            = (cnt_q != 2'd0) || (stage_q != IS_IDLE);
    assign instruction_id  = id_q;
    assign clock_counter   = cnt_q;
    assign interrupt_stage = stage_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (stall steps only with SEQ_STALL_EN).
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dec_id;
    logic       dec_valid;
    logic       branch_taken;
    logic       irq_req;
    logic       sreg_i;
    logic       stall;
    logic [7:0] instruction_id;
    logic [1:0] clock_counter;
    logic [1:0] interrupt_stage;
    logic       fetch_en;
    logic       irq_ack;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .dec_id          (dec_id),
        .dec_valid       (dec_valid),
        .branch_taken    (branch_taken),
        .irq_req         (irq_req),
        .sreg_i          (sreg_i),
`ifdef SEQ_STALL_EN
        .stall           (stall),
`endif
        .instruction_id  (instruction_id),
        .clock_counter   (clock_counter),
        .interrupt_stage (interrupt_stage),
        .fetch_en        (fetch_en),
        .irq_ack         (irq_ack),
        .busy            (busy)
    );

    task automatic applyStimulus(input logic [7:0] id, input logic valid, input logic taken,
                                 input logic irq, input logic sreg);
        dec_id       = id;
        dec_valid    = valid;
        branch_taken = taken;
        irq_req      = irq;
        sreg_i       = sreg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] e_id, input logic [1:0] e_cnt,
                               input logic [1:0] e_stage, input logic e_fetch, input logic e_ack,
                               input logic e_busy);
        logic [14:0] obs;
        logic [14:0] expv;
        obs  = {instruction_id, clock_counter, interrupt_stage, fetch_en, irq_ack, busy};
        expv = {e_id, e_cnt, e_stage, e_fetch, e_ack, e_busy};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: got id=%h cnt=%0d stg=%0d fe=%b ack=%b busy=%b, expected id=%h cnt=%0d stg=%0d fe=%b ack=%b busy=%b",
                   tag, instruction_id, clock_counter, interrupt_stage, fetch_en, irq_ack, busy,
                   e_id, e_cnt, e_stage, e_fetch, e_ack, e_busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("reset", 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // RCALL: three cycles
        reset = 1'b0;
        applyStimulus(8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("rcall_c2", 8'h2C, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("rcall_c1", 8'h2C, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("rcall_c0", 8'h2C, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Branch 05 taken / not taken
        applyStimulus(8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); checkOutput("br_taken", 8'h05, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("br_taken_end", 8'h05, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("br_not_taken", 8'h05, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("idle", 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Branch range edges and first id past the range
        applyStimulus(8'h08, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); checkOutput("br_hi_taken", 8'h08, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("br_hi_end", 8'h08, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h09, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); checkOutput("non_branch_09", 8'h09, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h04, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); checkOutput("br_lo_taken", 8'h04, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); checkOutput("br_lo_end", 8'h04, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick(); checkOutput("non_branch_03", 8'h03, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);

        // LPM: three cycles
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("lpm_c2", 8'h22, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("lpm_c1", 8'h22, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("lpm_c0", 8'h22, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);

        // RET with interrupt raised mid-instruction
        applyStimulus(8'h2D, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("ret_c3", 8'h2D, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); checkOutput("ret_c2_irq_held", 8'h2D, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("ret_c1", 8'h2D, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("ret_c0_irq_pend", 8'h2D, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("irq_pcl", 8'hFF, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("irq_pch_dropped", 8'hFF, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("irq_vec", 8'hFF, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1);
        tick(); checkOutput("irq_done", 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Interrupt masked by sreg_i, then enabled
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); checkOutput("irq_masked_a", 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick(); checkOutput("irq_masked_b", 8'h00, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h2B, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); checkOutput("irq_over_dec", 8'hFF, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
        tick(); checkOutput("irq_pch_2", 8'hFF, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);

        // Reset during stage 1 aborts entry
        reset = 1'b1;
        tick(); checkOutput("reset_mid_irq", 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(8'h2B, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("push_after_rst", 8'h2B, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("push_end", 8'h2B, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);

`ifdef SEQ_STALL_EN
        // Stall freezes RCALL at counter 1
        applyStimulus(8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("st_rcall_c2", 8'h2C, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); checkOutput("st_rcall_c1", 8'h2C, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); checkOutput("stall_hold", 8'h2C, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
        end
        stall = 1'b0;
        tick(); checkOutput("stall_release", 8'h2C, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
